// File: rtl/mem_stage_if.sv
// Data-cache port bundle between the memory stage (master) and the cache (slave).
interface mem_stage_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one data-cache access per memory op, stalls
// upstream until dhit, and registers the writeback bundle.
module mem_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        validIN,
  input  logic        flush,
  input  logic        writeRegIN,
  input  logic        MemtoRegIN,
  input  logic [1:0]  RWDSelIN,
  input  logic        dRENIN,
  input  logic        dWENIN,
  input  logic [31:0] resultIN,
  input  logic [31:0] busBIN,
  input  logic [4:0]  rwIN,
  input  logic [31:0] PCIncIN,
  mem_stage_if.master dmem,
  output logic        validOUT,
  output logic        writeRegOUT,
  output logic        MemtoRegOUT,
  output logic [1:0]  RWDSelOUT,
  output logic [31:0] resultOUT,
  output logic [31:0] loadOUT,
  output logic [4:0]  rwOUT,
  output logic [31:0] PCIncOUT,
  output logic        memStall,
  output logic [15:0] waitCount
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 16;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;
  logic   mem_op;

  // Holding registers for the access in flight
  logic [DW-1:0] h_result, h_busb, h_pcinc;
  logic [RW-1:0] h_rw;
  logic [1:0]    h_rwdsel;
  logic          h_dren, h_dwen, h_wr, h_m2r;

  // Cache port is driven straight from the holding registers, so it holds in IDLE
  assign dmem.dmemaddr  = h_result;
  assign dmem.dmemstore = h_busb;
  assign dmem.dmemWEN   = (state == ACCESS) & h_dwen;
  assign dmem.dmemREN   = (state == ACCESS) & h_dren & ~h_dwen;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and upstream stall
  always_comb begin
    state_nxt = state;
    memStall  = 1'b0;
    mem_op    = validIN & ~flush & (dRENIN | dWENIN);
    if (state == IDLE) begin
      memStall = mem_op;
      if (mem_op) state_nxt = ACCESS;
    end else begin
      memStall = ~dmem.dhit;
      if (dmem.dhit) state_nxt = IDLE;
    end
  end

  // Holding registers, writeback registers and wait counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      h_result    <= '0;
      h_busb      <= '0;
      h_pcinc     <= '0;
      h_rw        <= '0;
      h_rwdsel    <= '0;
      h_dren      <= 1'b0;
      h_dwen      <= 1'b0;
      h_wr        <= 1'b0;
      h_m2r       <= 1'b0;
      validOUT    <= 1'b0;
      writeRegOUT <= 1'b0;
      MemtoRegOUT <= 1'b0;
      RWDSelOUT   <= '0;
      resultOUT   <= '0;
      loadOUT     <= '0;
      rwOUT       <= '0;
      PCIncOUT    <= '0;
      waitCount   <= '0;
    end else if (state == IDLE) begin
      if (mem_op) begin
        h_result    <= resultIN;
        h_busb      <= busBIN;
        h_pcinc     <= PCIncIN;
        h_rw        <= rwIN;
        h_rwdsel    <= RWDSelIN;
        h_dren      <= dRENIN;
        h_dwen      <= dWENIN;
        h_wr        <= writeRegIN;
        h_m2r       <= MemtoRegIN;
        validOUT    <= 1'b0;
        writeRegOUT <= 1'b0;
      end else if (validIN && !flush) begin
        validOUT    <= 1'b1;
        writeRegOUT <= writeRegIN & ~dWENIN & (rwIN != RW'(0));
        MemtoRegOUT <= MemtoRegIN;
        RWDSelOUT   <= RWDSelIN;
        resultOUT   <= resultIN;
        rwOUT       <= rwIN;
        PCIncOUT    <= PCIncIN;
      end else begin
        validOUT    <= 1'b0;
        writeRegOUT <= 1'b0;
      end
    end else begin
      if (dmem.dhit) begin
        validOUT    <= 1'b1;
        writeRegOUT <= h_wr & ~h_dwen & (h_rw != RW'(0));
        MemtoRegOUT <= h_m2r;
        RWDSelOUT   <= h_rwdsel;
        resultOUT   <= h_result;
        rwOUT       <= h_rw;
        PCIncOUT    <= h_pcinc;
        if (h_dren && !h_dwen) loadOUT <= dmem.dmemload;
      end else begin
        validOUT    <= 1'b0;
        writeRegOUT <= 1'b0;
        if (waitCount != {CW{1'b1}}) waitCount <= waitCount + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a cycle-by-cycle vector table plus reset and
// wait-counter saturation sequences.
module tb_mem_stage;

  logic        CLK, RST;
  logic        validIN, flush, writeRegIN, MemtoRegIN, dRENIN, dWENIN;
  logic [1:0]  RWDSelIN;
  logic [31:0] resultIN, busBIN, PCIncIN;
  logic [4:0]  rwIN;
  logic        validOUT, writeRegOUT, MemtoRegOUT, memStall;
  logic [1:0]  RWDSelOUT;
  logic [31:0] resultOUT, loadOUT, PCIncOUT;
  logic [4:0]  rwOUT;
  logic [15:0] waitCount;

  int checks = 0;
  int errors = 0;

  mem_stage_if dbus();

  mem_stage dut (
    .CLK(CLK), .RST(RST),
    .validIN(validIN), .flush(flush), .writeRegIN(writeRegIN),
    .MemtoRegIN(MemtoRegIN), .RWDSelIN(RWDSelIN), .dRENIN(dRENIN),
    .dWENIN(dWENIN), .resultIN(resultIN), .busBIN(busBIN), .rwIN(rwIN),
    .PCIncIN(PCIncIN), .dmem(dbus),
    .validOUT(validOUT), .writeRegOUT(writeRegOUT), .MemtoRegOUT(MemtoRegOUT),
    .RWDSelOUT(RWDSelOUT), .resultOUT(resultOUT), .loadOUT(loadOUT),
    .rwOUT(rwOUT), .PCIncOUT(PCIncOUT), .memStall(memStall),
    .waitCount(waitCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    // inputs
    logic        valid, flsh, wr, m2r;
    logic [1:0]  rwdsel;
    logic        dren, dwen;
    logic [31:0] result, busb;
    logic [4:0]  rw;
    logic [31:0] pcinc;
    logic        dhit;
    logic [31:0] load_in;
    // expected before the edge
    logic        x_stall, x_ren, x_wen;
    logic [31:0] x_addr, x_store;
    // expected after the edge
    logic        x_valid, x_wr, x_m2r;
    logic [1:0]  x_rwdsel;
    logic [31:0] x_result, x_load;
    logic [4:0]  x_rw;
    logic [31:0] x_pcinc;
    logic [15:0] x_wc;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    validIN = 0; flush = 0; writeRegIN = 0; MemtoRegIN = 0; RWDSelIN = 0;
    dRENIN = 0; dWENIN = 0; resultIN = 0; busBIN = 0; rwIN = 0; PCIncIN = 0;
    dbus.dhit = 0; dbus.dmemload = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(validOUT), 0);
    check({tag, "_wr"}, 32'(writeRegOUT), 0);
    check({tag, "_result"}, resultOUT, 0);
    check({tag, "_load"}, loadOUT, 0);
    check({tag, "_rw"}, 32'(rwOUT), 0);
    check({tag, "_pcinc"}, PCIncOUT, 0);
    check({tag, "_wc"}, 32'(waitCount), 0);
    check({tag, "_ren"}, 32'(dbus.dmemREN), 0);
    check({tag, "_wen"}, 32'(dbus.dmemWEN), 0);
    check({tag, "_stall"}, 32'(memStall), 0);
  endtask

  task automatic apply(input int i, input vec_t v);
    validIN = v.valid; flush = v.flsh; writeRegIN = v.wr; MemtoRegIN = v.m2r;
    RWDSelIN = v.rwdsel; dRENIN = v.dren; dWENIN = v.dwen; resultIN = v.result;
    busBIN = v.busb; rwIN = v.rw; PCIncIN = v.pcinc;
    dbus.dhit = v.dhit; dbus.dmemload = v.load_in;
    #1;
    check($sformatf("v%0d_stall", i), 32'(memStall), 32'(v.x_stall));
    check($sformatf("v%0d_ren", i), 32'(dbus.dmemREN), 32'(v.x_ren));
    check($sformatf("v%0d_wen", i), 32'(dbus.dmemWEN), 32'(v.x_wen));
    check($sformatf("v%0d_addr", i), dbus.dmemaddr, v.x_addr);
    check($sformatf("v%0d_store", i), dbus.dmemstore, v.x_store);
    @(posedge CLK); #1;
    check($sformatf("v%0d_valid", i), 32'(validOUT), 32'(v.x_valid));
    check($sformatf("v%0d_wr", i), 32'(writeRegOUT), 32'(v.x_wr));
    check($sformatf("v%0d_m2r", i), 32'(MemtoRegOUT), 32'(v.x_m2r));
    check($sformatf("v%0d_rwdsel", i), 32'(RWDSelOUT), 32'(v.x_rwdsel));
    check($sformatf("v%0d_result", i), resultOUT, v.x_result);
    check($sformatf("v%0d_load", i), loadOUT, v.x_load);
    check($sformatf("v%0d_rw", i), 32'(rwOUT), 32'(v.x_rw));
    check($sformatf("v%0d_pcinc", i), PCIncOUT, v.x_pcinc);
    check($sformatf("v%0d_wc", i), 32'(waitCount), 32'(v.x_wc));
  endtask

  initial begin
    //          valid flsh wr m2r sel dren dwen result  busb          rw pcinc   dhit load
    //          | stall ren wen addr    store
    //          | valid wr m2r sel result  load          rw pcinc   wc
    // load, two wait states then dhit
    vecs[0]  = '{1,0,1,1,0,1,0,'h100,0,5,'h104,0,0,
                 1,0,0,0,0,
                 0,0,0,0,0,0,0,0,0};
    vecs[1]  = '{1,0,1,1,0,1,0,'h100,0,5,'h104,0,0,
                 1,1,0,'h100,0,
                 0,0,0,0,0,0,0,0,1};
    vecs[2]  = '{1,0,1,1,0,1,0,'h100,0,5,'h104,1,'hDEADBEEF,
                 0,1,0,'h100,0,
                 1,1,1,0,'h100,'hDEADBEEF,5,'h104,1};
    // store, dhit immediately (dhit while IDLE ignored)
    vecs[3]  = '{1,0,1,0,0,0,1,'h200,'h12345678,7,'h108,1,'hBAD,
                 1,0,0,'h100,0,
                 0,0,1,0,'h100,'hDEADBEEF,5,'h104,1};
    vecs[4]  = '{1,0,1,0,0,0,1,'h200,'h12345678,7,'h108,1,'hBAD,
                 0,0,1,'h200,'h12345678,
                 1,0,0,0,'h200,'hDEADBEEF,7,'h108,1};
    // ALU op, then same op flushed
    vecs[5]  = '{1,0,1,0,2,0,0,'h7,0,3,'h10C,0,0,
                 0,0,0,'h200,'h12345678,
                 1,1,0,2,'h7,'hDEADBEEF,3,'h10C,1};
    vecs[6]  = '{1,1,1,0,2,0,0,'h7,0,3,'h10C,0,0,
                 0,0,0,'h200,'h12345678,
                 0,0,0,2,'h7,'hDEADBEEF,3,'h10C,1};
    // ALU op targeting r0: no register write
    vecs[7]  = '{1,0,1,0,1,0,0,'h9,0,0,'h110,0,0,
                 0,0,0,'h200,'h12345678,
                 1,0,0,1,'h9,'hDEADBEEF,0,'h110,1};
    // invalid and flushed memory ops are bubbles
    vecs[8]  = '{0,0,1,0,0,1,0,'h300,0,6,'h114,0,0,
                 0,0,0,'h200,'h12345678,
                 0,0,0,1,'h9,'hDEADBEEF,0,'h110,1};
    vecs[9]  = '{1,1,1,0,0,1,0,'h300,0,6,'h118,1,'h77,
                 0,0,0,'h200,'h12345678,
                 0,0,0,1,'h9,'hDEADBEEF,0,'h110,1};
    // read+write: write wins; flush during stalled access ignored
    vecs[10] = '{1,0,1,0,0,1,1,'h400,'hCAFE,4,'h11C,0,0,
                 1,0,0,'h200,'h12345678,
                 0,0,0,1,'h9,'hDEADBEEF,0,'h110,1};
    vecs[11] = '{1,1,1,0,0,1,1,'h400,'hCAFE,4,'h11C,0,0,
                 1,0,1,'h400,'hCAFE,
                 0,0,0,1,'h9,'hDEADBEEF,0,'h110,2};
    vecs[12] = '{1,1,1,0,0,1,1,'h400,'hCAFE,4,'h11C,1,'h55,
                 0,0,1,'h400,'hCAFE,
                 1,0,0,0,'h400,'hDEADBEEF,4,'h11C,2};
    vecs[13] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,
                 0,0,0,'h400,'hCAFE,
                 0,0,0,0,'h400,'hDEADBEEF,4,'h11C,2};

    // Reset state
    do_reset();
    check_all_zero("rst");

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Reset during ACCESS with dhit high
    do_reset();
    validIN = 1; dRENIN = 1; writeRegIN = 1; resultIN = 'h500; rwIN = 9; PCIncIN = 'h200;
    @(posedge CLK); #1;
    check("racc_ren_before", 32'(dbus.dmemREN), 1);
    drive_idle();
    RST = 1; dbus.dhit = 1; dbus.dmemload = 'h1111;
    @(posedge CLK); #1;
    RST = 0; dbus.dhit = 0;
    #1;
    check_all_zero("racc");
    @(posedge CLK); #1;
    check("racc_novalid", 32'(validOUT), 0);
    check("racc_noload", loadOUT, 0);

    // Wait counter saturation
    do_reset();
    validIN = 1; dRENIN = 1; writeRegIN = 1; MemtoRegIN = 1; resultIN = 'h600; rwIN = 2;
    @(posedge CLK); #1;
    repeat (65534) @(posedge CLK);
    #1;
    check("sat_fffe", 32'(waitCount), 32'h0000FFFE);
    check("sat_stall", 32'(memStall), 1);
    repeat (70000 - 65534) @(posedge CLK);
    #1;
    check("sat_ffff", 32'(waitCount), 32'h0000FFFF);
    dbus.dhit = 1; dbus.dmemload = 'hA5A5A5A5;
    #1;
    check("sat_stall_hit", 32'(memStall), 0);
    @(posedge CLK); #1;
    drive_idle();
    check("sat_valid", 32'(validOUT), 1);
    check("sat_load", loadOUT, 32'hA5A5A5A5);
    check("sat_wr", 32'(writeRegOUT), 1);
    check("sat_hold", 32'(waitCount), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
